// File: rtl/burst_write_ram.sv
// Burst-write RAM: a command/stream channel fills memory at sequential wrapping
// addresses; the registered read port works independently of the write FSM.
module burst_write_ram #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, rem;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  xfer;

  assign xfer = (state == WRITE) && wr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = WRITE;
      end
      WRITE: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (wr_valid && rem == '0) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rem counts words still owed after the current one; zero marks the last word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      rem <= '0;
    end else if (state == IDLE && cmd_valid) begin
      ptr <= cmd_addr;
      rem <= cmd_len;
    end else if (xfer) begin
      ptr <= ptr + 1'b1;
      if (rem != '0) rem <= rem - 1'b1;
    end
  end

  // Contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (xfer) mem[ptr] <= wr_data;
  end

  // Nonblocking read of the array makes a same-edge collision read-first
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: doc/burst_write_ram.md
Name: burst_write_ram

Overview:
- Writable companion to the team's 1-port synchronous ROM. It fills an internal memory array through a burst write channel and exposes the same registered read port as the ROM.
- The write channel is a command handshake (start address plus length) followed by a valid/ready data stream. Words are written to sequential, wrapping addresses.
- Sits between a loader/host stream and consumers that read stored tables.

Parameters:
- ADDR_WIDTH, 3, address width; memory depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 8, width of each stored word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  burst command present.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_addr  input  ADDR_WIDTH  burst start address.
- cmd_len  input  ADDR_WIDTH  burst length minus one (0 means 1 word; all-ones means full depth).
- wr_valid  input  1  write data word present.
- wr_ready  output  1  block accepts write data (high only in WRITE).
- wr_data  input  DATA_WIDTH  write data word.
- busy  output  1  burst in progress (state WRITE or DONE).
- done  output  1  one-cycle pulse after the last word of a burst is written.
- rd_en  input  1  read enable.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, rd_data=0, done=0, busy=0, internal pointer and remaining counter = 0.
  - cmd_ready=1 and wr_ready=0 as decodes of IDLE.
  - Memory contents are not cleared by reset.
- FSM states: IDLE, WRITE, DONE.
  - IDLE: cmd_ready=1. On cmd_valid at a clock edge, capture ptr<=cmd_addr and rem<=cmd_len, then go to WRITE.
  - WRITE: wr_ready=1. A word transfers on any edge with wr_valid=1. The transfer writes mem[ptr]<=wr_data and sets ptr<=ptr+1 modulo 2**ADDR_WIDTH (wraps from max to 0).
    - If rem==0, go to DONE.
    - Otherwise rem<=rem-1.
    - With wr_valid=0, hold all state; there is no timeout.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally. cmd_ready=0 in DONE, so back-to-back commands are separated by at least one cycle.
- Burst latency: a command with cmd_len=N and wr_valid held high takes:
  - 1 cycle for command accept,
  - N+1 cycles of data,
  - 1 DONE cycle.
- A word written on edge k is readable via the read port from edge k+1 onward.
- Read port (independent of FSM, usable in any state):
  - On a clock edge with rd_en=1: rd_data<=mem[rd_addr], giving 1-cycle latency.
  - With rd_en=0: rd_data holds its previous value.
- Collision (same address read and written on one edge): the read is read-first and returns the old contents. The new value appears on the next read.
- Reset mid-burst: the FSM aborts to IDLE immediately. Words already written persist, and the remaining words of the burst are never written. done does not pulse.
- Inputs are ignored while they are not handshaken: wr_valid in IDLE/DONE and cmd_valid in WRITE/DONE have no effect.
- A burst longer than the depth is impossible by construction (cmd_len max = depth-1). A wrap overwrites nothing twice within one burst.
- Unknown (x) rd_addr with rd_en=1 yields x on rd_data; this is not checked by the RTL.

Test Plan:
1. Reset then idle: assert rst mid-cycle with no clock edge -> rd_data=0, cmd_ready=1, wr_ready=0, busy=0, done=0 immediately.
2. Basic burst: cmd_addr=2, cmd_len=3, then data 0x11,0x22,0x33,0x44 with wr_valid high -> mem[2..5]=0x11..0x44. done pulses exactly one cycle, 5 cycles after command accept. Reads of addresses 2..5 with rd_en=1 return 0x11..0x44 one cycle after each address.
3. Wrap-around: cmd_addr=6, cmd_len=3, data 0xA0,0xA1,0xA2,0xA3 -> mem[6]=0xA0, mem[7]=0xA1, mem[0]=0xA2, mem[1]=0xA3.
4. Stalled stream and handshake gating:
   - Toggle wr_valid (1,0,0,1,...) during a 2-word burst -> only handshaken words are written; wr_ready stays high while in WRITE.
   - cmd_valid pulsed during WRITE is ignored; cmd_ready=0 in WRITE and DONE.
5. Read-first collision: mem[4]=0x0F. Write 0xF0 to address 4 while rd_en=1 and rd_addr=4 on the same edge -> rd_data=0x0F. The next read returns 0xF0. With rd_en=0, rd_data holds.
6. Reset mid-burst: cmd_addr=0, cmd_len=7. Assert rst after 3 words -> mem[0..2] written and mem[3..7] unchanged. State returns to IDLE with no done pulse. A new burst after reset completes normally.
